vend_credit_ctrl: RTL
=====================

// Module: vend_credit_ctrl
// PURPOSE
//   Multi-channel vending credit controller. Accepts debounced single-cycle coin pulses, accumulates credit
//   with saturation, serves vend/refund requests through pulse handshakes, and drives the multiplexed
//   active-low 7-segment display. Sits between the input_db debouncers and the board anodes/cathodes.
// PARAMETERS
//   NUM_COINS   3           number of coin channels
//   COIN_VALUES {8'd3,8'd2,8'd1}  packed 8-bit value per channel; channel i = COIN_VALUES[8*i+:8]
//   CREDIT_W    14          credit register width
//   MAX_CREDIT  9999        saturation ceiling; must be < 10**NUM_DIGITS and < 2**CREDIT_W
//   NUM_DIGITS  4           displayed decimal digits (1..8)
//   REFRESH_W   20          display refresh counter width; digit select = top clog2(NUM_DIGITS) bits
// PORTS
//   clock         in   1           system clock
//   reset         in   1           asynchronous, active-low reset
//   coin_pulse    in   NUM_COINS   one-cycle pulse per inserted coin
//   price         in   CREDIT_W    item price, sampled in the vend_req cycle
//   vend_req      in   1           one-cycle vend request
//   refund_req    in   1           one-cycle refund request
//   credit        out  CREDIT_W    current registered credit
//   vend_ack      out  1           one-cycle pulse: vend accepted
//   vend_nak      out  1           one-cycle pulse: vend refused
//   change_valid  out  1           one-cycle pulse qualifying change_amt
//   change_amt    out  CREDIT_W    amount returned; held until next change_valid
//   coin_reject   out  1           one-cycle pulse: coin sum would exceed MAX_CREDIT, coins discarded
//   seg_an        out  8           anodes, active-low; digits >= NUM_DIGITS held 1
//   seg_cat       out  7           cathodes {a..g}, active-low (0=7'b0000001 ... 9=7'b0000100)
// BEHAVIOUR
//   Reset: credit=0, all pulses=0, change_amt=0, refresh counter=0, displayed BCD=0, seg_an = digit 0 on.
//   coin_sum = sum of COIN_VALUES over all asserted coin_pulse bits (simultaneous coins add together).
//   Cycle n inputs -> registered outputs at edge n+1 (1-cycle latency for every pulse and credit).
//   Priority per cycle: refund_req > vend_req; coins always evaluated in the same cycle.
//   Refund: change_amt=credit, change_valid=1, credit=coin_sum (subject to saturation check vs 0).
//   Vend: if price!=0 and credit>=price -> vend_ack, base=credit-price; else vend_nak, base=credit.
//     Vend compares against registered credit only; same-cycle coins do not fund the vend.
//   Idle: base=credit. Next credit = base+coin_sum if <= MAX_CREDIT, else base and coin_reject=1.
//   vend_req and refund_req together: refund wins, no vend_ack/vend_nak issued.
//   FSM {IDLE, ACK, CHANGE}: IDLE->ACK on accepted vend; ACK->CHANGE only with AUTO_CHANGE_EN and
//     credit!=0, else ->IDLE; CHANGE->IDLE after one cycle. Requests arriving in ACK/CHANGE: vend_nak /
//     ignored refund; coins still accepted.
//   Display: each credit change starts the BCD converter (restarts if busy); on done, displayed BCD
//     latched atomically. Digit k shows BCD nibble k (k=0 rightmost, seg_an bit 0). Counter wraps freely.
//   Reset asserted mid-conversion or mid-FSM: everything returns to reset values immediately.
// CONFIGURATION
//   AUTO_CHANGE_EN defined: in CHANGE state change_amt=credit, change_valid=1, credit=0+coin_sum.
//   Not defined: remaining credit retained after vend; change only via refund_req; CHANGE unreachable.
// STRUCTURE
//   Package vend_pkg: state enum (IDLE/ACK/CHANGE), 7-seg digit pattern table, BCD nibble width const,
//     coin-value extraction function.
//   Sub-module bin2bcd_seq: sequential double-dabble, CREDIT_W+1 cycles, ports start/bin/busy/done/bcd
//     [4*NUM_DIGITS-1:0]; same clock/reset.
// TESTING
//   1 Reset, pulse coin_pulse=3'b001 then 3'b010 then 3'b100 -> credit 1,3,6; display reads 0006.
//   2 coin_pulse=3'b111 one cycle from credit 0 -> credit=6 next cycle, no coin_reject.
//   3 credit=5, price=4, vend_req -> vend_ack, credit=1; AUTO_CHANGE_EN: next cycle change_valid,
//     change_amt=1, credit=0. Without it: credit stays 1.
//   4 credit=3, price=4 vend_req -> vend_nak, credit=3; price=0 -> vend_nak.
//   5 credit=9998, coin 3'b010 -> coin_reject, credit 9998; coin 3'b001 -> credit 9999.
//   6 credit=7, refund_req+vend_req+coin 3'b001 same cycle -> change_amt=7, credit=1, no ack/nak;
//     reset low mid-conversion -> credit 0, display 0000.

Source files
------------

// File: rtl/vend_credit_ctrl_pkg.sv
// rtl/vend_credit_ctrl_pkg.sv - shared types and helpers for the vending credit controller
//
// Purpose : FSM state enum, BCD nibble width, 7-segment digit table and
//           coin-value extraction used by vend_credit_ctrl and bin2bcd_seq.
// Ports   : none (package).
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    CHANGE = 2'd2
  } vend_state_e;

  localparam int BCD_W = 4;

  // Active-low cathodes ordered {a,b,c,d,e,f,g}; non-decimal codes blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0000100;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Value of coin channel idx from a packed 8-bit-per-channel table
  // (table zero-extended to 256 bits, so up to 32 channels).
  function automatic logic [7:0] coin_value(input logic [255:0] values, input int idx);
    return values[8*idx +: 8];
  endfunction

endpackage

// File: rtl/vend_credit_ctrl_if.sv
// rtl/vend_credit_ctrl_if.sv - coin/request/response bundle of the credit controller
//
// Purpose : groups coin pulses, vend/refund requests and the credit/change
//           responses. master = requester side, slave = vend_credit_ctrl.
// Signals : coin_pulse, price, vend_req, refund_req (master -> slave);
//           credit, vend_ack, vend_nak, change_valid, change_amt,
//           coin_reject (slave -> master).
interface vend_credit_ctrl_if #(
  parameter int NUM_COINS = 3,
  parameter int CREDIT_W  = 14
);
  logic [NUM_COINS-1:0] coin_pulse;
  logic [CREDIT_W-1:0]  price;
  logic                 vend_req;
  logic                 refund_req;
  logic [CREDIT_W-1:0]  credit;
  logic                 vend_ack;
  logic                 vend_nak;
  logic                 change_valid;
  logic [CREDIT_W-1:0]  change_amt;
  logic                 coin_reject;

  modport master (
    output coin_pulse, price, vend_req, refund_req,
    input  credit, vend_ack, vend_nak, change_valid, change_amt, coin_reject
  );

  modport slave (
    input  coin_pulse, price, vend_req, refund_req,
    output credit, vend_ack, vend_nak, change_valid, change_amt, coin_reject
  );
endinterface

// File: rtl/vend_credit_ctrl_bin2bcd.sv
// rtl/vend_credit_ctrl_bin2bcd.sv - sequential double-dabble binary to BCD converter
//
// Purpose : converts i_bin to NUM_DIGITS packed BCD nibbles, one shift per
//           cycle. A start pulse loads (or reloads, if busy) the operand;
//           o_done pulses CREDIT_W+1 cycles after the start cycle.
// Ports   : i_clock, i_reset (async active-low), i_start, i_bin[CREDIT_W],
//           o_busy, o_done, o_bcd[4*NUM_DIGITS] (valid while o_done is high).
module bin2bcd_seq
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [CREDIT_W-1:0]         i_bin,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [BCD_W*NUM_DIGITS-1:0] o_bcd
);
  localparam int BCD_BITS = BCD_W * NUM_DIGITS;
  localparam int CNT_W    = $clog2(CREDIT_W + 1);

  logic [CREDIT_W-1:0] r_bin;
  logic [BCD_BITS-1:0] r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [BCD_BITS-1:0] w_adj;

  // Add 3 to every nibble >= 5 before the shift so it carries correctly.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[BCD_W*k +: BCD_W] >= 4'd5)
        w_adj[BCD_W*k +: BCD_W] = r_bcd[BCD_W*k +: BCD_W] + 4'd3;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_bin  <= i_bin;
        r_bcd  <= '0;
        r_cnt  <= CNT_W'(CREDIT_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_bcd <= {w_adj[BCD_BITS-2:0], r_bin[CREDIT_W-1]};
        r_bin <= {r_bin[CREDIT_W-2:0], 1'b0};
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;
endmodule

// File: rtl/vend_credit_ctrl.sv
// rtl/vend_credit_ctrl.sv - multi-channel vending credit controller with 7-segment display
//
// Purpose : accumulates coin credit with saturation at MAX_CREDIT, serves
//           vend/refund pulse requests (refund wins), and scans the credit
//           in decimal onto a multiplexed active-low 7-segment display.
//           All responses are registered: inputs of cycle n appear at edge n+1.
// Ports   : i_clock, i_reset (async active-low),
//           bus (vend_credit_ctrl_if.slave: coins/requests in, credit/acks/change out),
//           o_seg_an[8] anodes (active-low), o_seg_cat[7] cathodes {a..g} (active-low).
// Config  : AUTO_CHANGE_EN - when defined, an accepted vend with remaining
//           credit is followed by an automatic change payout (CHANGE state).
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int                     NUM_COINS   = 3,
  parameter logic [8*NUM_COINS-1:0] COIN_VALUES = {8'd3, 8'd2, 8'd1},
  parameter int                     CREDIT_W    = 14,
  parameter int                     MAX_CREDIT  = 9999,
  parameter int                     NUM_DIGITS  = 4,
  parameter int                     REFRESH_W   = 20
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  vend_credit_ctrl_if.slave       bus,
  output logic [7:0]              o_seg_an,
  output logic [6:0]              o_seg_cat
);
  localparam int BCD_BITS = BCD_W * NUM_DIGITS;
  localparam int SEL_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  vend_state_e         r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt, w_base;
  logic                r_vend_ack, r_vend_nak, r_change_valid, r_coin_reject;
  logic [CREDIT_W-1:0] r_change_amt, w_change_amt;
  logic                w_ack, w_nak, w_chg, w_rej;
  logic [31:0]         w_coin_sum, w_total;

  logic [REFRESH_W-1:0] r_refresh;
  logic [BCD_BITS-1:0]  r_disp_bcd, w_bcd;
  logic                 w_conv_busy, w_conv_done;
  logic [SEL_W-1:0]     w_sel;
  logic [3:0]           w_digit;

  always_comb begin
    w_coin_sum = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (bus.coin_pulse[i])
        w_coin_sum = w_coin_sum + 32'(coin_value(256'(COIN_VALUES), i));
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, response pulses and next credit. Vends are judged against
  // registered credit only; coins of the same cycle land on top of the base.
  always_comb begin
    w_state_nxt  = r_state;
    w_base       = r_credit;
    w_ack        = 1'b0;
    w_nak        = 1'b0;
    w_chg        = 1'b0;
    w_rej        = 1'b0;
    w_change_amt = r_change_amt;
    w_credit_nxt = r_credit;
    w_total      = '0;
    case (r_state)
      IDLE: begin
        if (bus.refund_req) begin
          w_chg        = 1'b1;
          w_change_amt = r_credit;
          w_base       = '0;
        end else if (bus.vend_req) begin
          if ((bus.price != '0) && (r_credit >= bus.price)) begin
            w_ack       = 1'b1;
            w_base      = r_credit - bus.price;
            w_state_nxt = ACK;
          end else begin
            w_nak = 1'b1;
          end
        end
      end
      ACK: begin
        // Refunds are dropped while a vend is being completed.
        w_nak = bus.vend_req;
`ifdef AUTO_CHANGE_EN
        w_state_nxt = (r_credit != '0) ? CHANGE : IDLE;
`else
        w_state_nxt = IDLE;
`endif
      end
      CHANGE: begin
        w_nak        = bus.vend_req;
        w_chg        = 1'b1;
        w_change_amt = r_credit;
        w_base       = '0;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_total = 32'(w_base) + w_coin_sum;
    if (w_total <= 32'(MAX_CREDIT)) begin
      w_credit_nxt = w_total[CREDIT_W-1:0];
    end else begin
      w_credit_nxt = w_base;
      w_rej        = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_credit       <= '0;
      r_vend_ack     <= 1'b0;
      r_vend_nak     <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_amt   <= '0;
      r_coin_reject  <= 1'b0;
    end else begin
      r_credit       <= w_credit_nxt;
      r_vend_ack     <= w_ack;
      r_vend_nak     <= w_nak;
      r_change_valid <= w_chg;
      r_change_amt   <= w_change_amt;
      r_coin_reject  <= w_rej;
    end
  end

  assign bus.credit       = r_credit;
  assign bus.vend_ack     = r_vend_ack;
  assign bus.vend_nak     = r_vend_nak;
  assign bus.change_valid = r_change_valid;
  assign bus.change_amt   = r_change_amt;
  assign bus.coin_reject  = r_coin_reject;

  // Conversion starts on the edge that updates credit, from the new value,
  // so a burst of changes keeps restarting and only the final value lands.
  bin2bcd_seq #(
    .CREDIT_W   (CREDIT_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (w_credit_nxt != r_credit),
    .i_bin   (w_credit_nxt),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_refresh  <= '0;
      r_disp_bcd <= '0;
    end else begin
      r_refresh <= r_refresh + REFRESH_W'(1);
      // Whole-number latch: the display never shows a partially shifted value.
      if (w_conv_done && !w_conv_busy)
        r_disp_bcd <= w_bcd;
    end
  end

  assign w_sel = (NUM_DIGITS > 1) ? r_refresh[REFRESH_W-1 -: SEL_W] : '0;

  always_comb begin
    o_seg_an = 8'hFF;
    w_digit  = '0;
    if (int'(w_sel) < NUM_DIGITS) begin
      o_seg_an[w_sel] = 1'b0;
      w_digit         = r_disp_bcd[BCD_W*w_sel +: BCD_W];
    end
    o_seg_cat = seg_pattern(w_digit);
  end
endmodule
